sequential_divider: RTL and testbench



---
 rtl/sequential_divider_pkg.sv | 29 ++
 rtl/sequential_divider_div_step.sv | 20 ++
 rtl/sequential_divider.sv | 76 +++++++
 tb/tb_sequential_divider.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sequential_divider_pkg.sv
// Shared widths, frame timing constants and frame-phase decode for sequential_divider.
package sequential_divider_pkg;

   localparam int OPERAND_W  = 16;
   localparam int QUOTIENT_W = 8;
   localparam int REM_W      = 17;
   localparam int FRAME_LEN  = 256;
   localparam int CNT_W      = $clog2(FRAME_LEN);

   localparam logic [CNT_W-1:0]      CAPTURE_CNT   = CNT_W'(0);
   localparam logic [CNT_W-1:0]      LAST_STEP_CNT = CNT_W'(8);
   localparam logic [CNT_W-1:0]      COMMIT_CNT    = CNT_W'(FRAME_LEN - 1);
   localparam logic [QUOTIENT_W-1:0] QUOTIENT_SAT  = 8'hFF;

   typedef enum logic [1:0] {
      PH_CAPTURE,
      PH_STEP,
      PH_IDLE,
      PH_COMMIT
   } phase_e;

   function automatic phase_e frame_phase(input logic [CNT_W-1:0] cnt);
      if (cnt == CAPTURE_CNT)        return PH_CAPTURE;
      else if (cnt <= LAST_STEP_CNT) return PH_STEP;
      else if (cnt == COMMIT_CNT)    return PH_COMMIT;
      else                           return PH_IDLE;
   endfunction

endpackage

// File: rtl/sequential_divider_div_step.sv
// One combinational restoring-division step: doubles the remainder and subtracts the divisor when it fits.
module div_step
   import sequential_divider_pkg::*;
(
   input  logic [REM_W-1:0]     r,
   input  logic [OPERAND_W-1:0] d,
   output logic [REM_W-1:0]     r_next,
   output logic                 q_bit
);

   logic [REM_W:0]   r2;
   logic [REM_W-1:0] diff;

   assign r2 = {r, 1'b0};
   assign q_bit = (r2 >= {2'b00, d});
   // R < D keeps the doubled remainder below 2^17, so the narrow subtract is exact.
   assign diff = r2[REM_W-1:0] - {1'b0, d};
   assign r_next = q_bit ? diff : r2[REM_W-1:0];

endmodule

// File: rtl/sequential_divider.sv
// Frame-based 8-bit ratio unit: quotient = min(255, floor(dividend*256/divider)), refreshed every 256 enabled cycles.
// Optional `done` strobe after each commit is enabled with SEQUENTIAL_DIVIDER_DONE_EN.
module sequential_divider
   import sequential_divider_pkg::*;
(
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  en,
   input  logic [OPERAND_W-1:0]  divider,
   input  logic [OPERAND_W-1:0]  dividend,
   output logic [QUOTIENT_W-1:0] quotient
`ifdef SEQUENTIAL_DIVIDER_DONE_EN
   ,
   output logic                  done
`endif
);

   logic [CNT_W-1:0]      cnt;
   logic [OPERAND_W-1:0]  d_reg;
   logic [REM_W-1:0]      r_reg;
   logic [QUOTIENT_W-1:0] a_reg;
   logic                  sat;
   logic [REM_W-1:0]      step_r;
   logic                  step_q;
   phase_e                phase;

   assign phase = frame_phase(cnt);

   div_step u_div_step (
      .r      (r_reg),
      .d      (d_reg),
      .r_next (step_r),
      .q_bit  (step_q)
   );

   // NOTE: every state register, including the datapath, takes the async reset so
   // reset values are defined immediately and not after the first clock edge.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt      <= '0;
         d_reg    <= '0;
         r_reg    <= '0;
         a_reg    <= '0;
         sat      <= 1'b0;
         quotient <= '0;
      end else if (!en) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
         unique case (phase)
            PH_CAPTURE: begin
               d_reg <= divider;
               r_reg <= {1'b0, dividend};
               a_reg <= '0;
               sat   <= (divider == '0) || (dividend >= divider);
            end
            PH_STEP: begin
               if (!sat) begin
                  r_reg <= step_r;
                  a_reg <= {a_reg[QUOTIENT_W-2:0], step_q};
               end
            end
            PH_COMMIT: quotient <= sat ? QUOTIENT_SAT : a_reg;
            default: ;
         endcase
      end
   end

`ifdef SEQUENTIAL_DIVIDER_DONE_EN
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) done <= 1'b0;
      else       done <= en && (cnt == COMMIT_CNT);
   end
`endif

endmodule

// File: tb/tb_sequential_divider.sv
// Directed self-checking bench for sequential_divider; done checks activate with SEQUENTIAL_DIVIDER_DONE_EN.
`timescale 1ns/100ps
module tb_sequential_divider;

   logic        tb_clk;
   logic        nrst;
   logic        en;
   logic [15:0] divider;
   logic [15:0] dividend;
   logic [7:0]  quotient;
`ifdef SEQUENTIAL_DIVIDER_DONE_EN
   logic        done;
`endif

   int n_checks = 0;
   int n_errors = 0;

   sequential_divider dut (
      .clk      (tb_clk),
      .nrst     (nrst),
      .en       (en),
      .divider  (divider),
      .dividend (dividend),
      .quotient (quotient)
`ifdef SEQUENTIAL_DIVIDER_DONE_EN
      ,
      .done     (done)
`endif
   );

   initial tb_clk = 1'b1;
   always #5 tb_clk = ~tb_clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic check_done(input string tag, input logic expected);
`ifdef SEQUENTIAL_DIVIDER_DONE_EN
      check(tag, {31'b0, done}, {31'b0, expected});
`else
      if (expected === 1'bx) $display("unused %s", tag);
`endif
   endtask

   // Advance n rising edges, then sample 1 ns after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge tb_clk);
      #1;
   endtask

   // Called 1 ns after a commit edge: next edge captures, 256th edge commits.
   task automatic run_frame(input string tag, input logic [15:0] num, input logic [15:0] den,
                            input logic [7:0] prev, input logic [7:0] expected);
      dividend = num;
      divider  = den;
      tick(255);
      check({tag, "_pre"}, quotient, prev);
      check_done({tag, "_done_pre"}, 1'b0);
      tick(1);
      check(tag, quotient, expected);
      check_done({tag, "_done"}, 1'b1);
   endtask

   initial begin
      nrst     = 1'b0;
      en       = 1'b0;
      dividend = '0;
      divider  = '0;
      #1;
      check("reset_q", quotient, 0);
      check_done("reset_done", 1'b0);
      @(posedge tb_clk); #1;
      check("reset_edge_q", quotient, 0);
      @(negedge tb_clk);
      nrst     = 1'b1;
      en       = 1'b1;
      dividend = 16'd22000;
      divider  = 16'd22727;
      #1.1;
      check("release_q", quotient, 0);

      // First result: 22000*256/22727 = 247.8 -> 247, commit on 256th edge from capture.
      tick(255);
      check("first_latency", quotient, 0);
      tick(1);
      check("first_result", quotient, 247);
      check_done("first_done", 1'b1);
      tick(1);
      check_done("done_one_cycle", 1'b0);
      tick(11);
      check("hold_267", quotient, 247);
      tick(244);
      check("hold_next_frame", quotient, 247);
      check_done("hold_done", 1'b1);

      run_frame("equal", 16'd22727, 16'd22727, 8'd247, 8'd255);
      run_frame("zero_num", 16'd0, 16'd22727, 8'd255, 8'd0);
      tick(256);
      check("zero_stays", quotient, 0);
      run_frame("zero_den", 16'd1234, 16'd0, 8'd0, 8'd255);
      run_frame("half", 16'd11363, 16'd22727, 8'd255, 8'd127);
      run_frame("sat_over", 16'd22728, 16'd22727, 8'd127, 8'd255);
      // 1*256/3 = 85.33 -> 85; 40000*256/65535 = 156.25 -> 156
      run_frame("third", 16'd1, 16'd3, 8'd255, 8'd85);
      run_frame("wide_den", 16'd40000, 16'd65535, 8'd85, 8'd156);

      // Inputs changed after capture must not affect the frame in flight.
      dividend = 16'd11363;
      divider  = 16'd22727;
      tick(2);
      dividend = 16'd0;
      tick(254);
      check("late_change_ignored", quotient, 127);
      tick(256);
      check("late_change_next", quotient, 0);

      // Drop en mid-frame: output holds, partial frame discarded.
      dividend = 16'd11363;
      tick(100);
      en = 1'b0;
      tick(50);
      check("en_low_hold", quotient, 0);
      check_done("en_low_done", 1'b0);
      en = 1'b1;
      tick(255);
      check("reenable_pre", quotient, 0);
      tick(1);
      check("reenable_result", quotient, 127);
      check_done("reenable_done", 1'b1);

      // Async reset mid-frame clears immediately.
      tick(50);
      #2 nrst = 1'b0;
      #1;
      check("midframe_reset_q", quotient, 0);
      check_done("midframe_reset_done", 1'b0);
      tick(1);
      check("midframe_reset_edge", quotient, 0);
      @(negedge tb_clk);
      nrst = 1'b1;
      tick(255);
      check("post_reset_pre", quotient, 0);
      tick(1);
      check("post_reset_result", quotient, 127);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
